// File: rtl/dma_rx_dscq_arb_pkg.sv
// Shared types and helpers for the RX descriptor-queue write arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dma_rx_dscq_arb_pkg;

    localparam int DSC_ADDR_W = 58;
    localparam int DSC_LEN_W  = 26;

    // One descriptor as produced by a channel's graph-host logic.
    // Address and sizes are kept in 64-byte units, hence the [..:6] ranges.
    typedef struct packed {
        logic [63:6] src_addr;
        logic [31:6] src_len;
        logic [31:6] rp_pros;
    } dsc_t;

    // Index of the set bit in a one-hot vector of up to 32 requesters.
    // An all-zero vector yields 0.
    function automatic logic [4:0] rr_oh2idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_rx_rr_arb.sv
// Round-robin arbiter over N requesters. Search starts just after the last grant.
// Latency: grant is combinational from i_req; the pointer register updates at the edge.
// Backpressure: the pointer only moves when i_adv=1 and some request is present.
// Ports: i_clk, i_reset (sync, active-high), i_req[N], i_adv -> o_gnt (one-hot),
//        o_idx (granted index), o_ptr (last-grant pointer).
module dma_rx_rr_arb
    import dma_rx_dscq_arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N-1:0]     i_req,
    input  logic             i_adv,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic [IDX_W-1:0] o_ptr
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;
    int               w_j;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_j     = 0;
        // Walk ptr+1, ptr+2, ... wrapping; the last-granted channel is checked last.
        for (int k = 1; k <= N; k++) begin
            w_j = (int'(r_ptr) + k) % N;
            if (!w_found && i_req[IDX_W'(w_j)]) begin
                o_gnt[IDX_W'(w_j)] = 1'b1;
                w_found            = 1'b1;
            end
        end
    end

    assign o_idx = IDX_W'(rr_oh2idx(32'(o_gnt)));
    assign o_ptr = r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // Last grant = N-1 makes channel 0 the first candidate.
            r_ptr <= IDX_W'(N - 1);
        end else if (i_adv && (|i_req)) begin
            r_ptr <= o_idx;
        end
    end

endmodule

// File: rtl/dma_rx_dscq_arb.sv
// Funnels per-channel descriptor write pulses through one-entry slots into the single DSCQ write port.
// Latency: 1 cycle from an eligible slot to dscq_we; sustains 1 write per cycle.
// Backpressure: dscq_full stalls grants; occupied slots raise ch_dscq_full, extra pulses set ch_set_err_ovfl.
// Ports: user_clk/reset; per-channel ch_dscq_we + descriptor fields + ch_rxch_clr_exec in;
//        dscq_full, reg_dma_rx_err_1wc in; DSCQ write (dscq_we/chid/fields) and per-channel status out.
module dma_rx_dscq_arb
    import dma_rx_dscq_arb_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int CHID_W = $clog2(CH_NUM)
) (
    input  logic                          user_clk,
    input  logic                          reset,
    input  logic [CH_NUM-1:0]             ch_dscq_we,
    input  logic [CH_NUM*DSC_ADDR_W-1:0]  ch_dsc_src_addr,
    input  logic [CH_NUM*DSC_LEN_W-1:0]   ch_dsc_src_len,
    input  logic [CH_NUM*DSC_LEN_W-1:0]   ch_dsc_srbuf_rp_pros,
    input  logic [CH_NUM-1:0]             ch_rxch_clr_exec,
    input  logic                          dscq_full,
    input  logic                          reg_dma_rx_err_1wc,
    output logic [CH_NUM-1:0]             ch_dscq_full,
    output logic                          dscq_we,
    output logic [CHID_W-1:0]             dscq_chid,
    output logic [DSC_ADDR_W-1:0]         dscq_src_addr,
    output logic [DSC_LEN_W-1:0]          dscq_src_len,
    output logic [DSC_LEN_W-1:0]          dscq_srbuf_rp_pros,
    output logic [CH_NUM-1:0]             ch_arb_busy,
    output logic [CH_NUM-1:0]             ch_set_err_ovfl
);

    dsc_t              w_in_dsc [CH_NUM];
    dsc_t              r_slot   [CH_NUM];
    logic [CH_NUM-1:0] r_slot_vld;
    logic [CH_NUM-1:0] r_err;

    logic [CH_NUM-1:0] w_elig;
    logic [CH_NUM-1:0] w_req;
    logic [CH_NUM-1:0] w_gnt;
    logic [CHID_W-1:0] w_gnt_idx;
    logic [CHID_W-1:0] w_ptr;
    logic [CH_NUM-1:0] w_cap;
    logic [CH_NUM-1:0] w_ovf;
    logic [CH_NUM-1:0] w_vld_nxt;

    logic              r_dscq_we;
    logic [CHID_W-1:0] r_dscq_chid;
    dsc_t              r_dscq_dsc;

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            w_in_dsc[i].src_addr = ch_dsc_src_addr[i*DSC_ADDR_W +: DSC_ADDR_W];
            w_in_dsc[i].src_len  = ch_dsc_src_len[i*DSC_LEN_W +: DSC_LEN_W];
            w_in_dsc[i].rp_pros  = ch_dsc_srbuf_rp_pros[i*DSC_LEN_W +: DSC_LEN_W];
        end
    end

    // A channel being cleared drops out of the search so the arbiter can pick
    // the next eligible channel in the same cycle.
    assign w_elig = r_slot_vld & ~ch_rxch_clr_exec;
    assign w_req  = dscq_full ? '0 : w_elig;

    dma_rx_rr_arb #(
        .N     (CH_NUM),
        .IDX_W (CHID_W)
    ) u_rr_arb (
        .i_clk   (user_clk),
        .i_reset (reset),
        .i_req   (w_req),
        .i_adv   (~dscq_full),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_ptr   (w_ptr)
    );

    // A slot being drained this cycle can accept a new descriptor back-to-back.
    assign w_cap     = ch_dscq_we & ~ch_rxch_clr_exec & (~r_slot_vld | w_gnt);
    assign w_ovf     = ch_dscq_we & r_slot_vld & ~w_gnt;
    assign w_vld_nxt = (r_slot_vld & ~w_gnt & ~ch_rxch_clr_exec) | w_cap;

    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_slot_vld  <= '0;
            r_err       <= '0;
            r_dscq_we   <= 1'b0;
            r_dscq_chid <= '0;
            r_dscq_dsc  <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_slot_vld <= w_vld_nxt;
            // A fresh overflow wins over a simultaneous write-1-clear.
            r_err      <= (r_err & ~{CH_NUM{reg_dma_rx_err_1wc}}) | w_ovf;
            for (int i = 0; i < CH_NUM; i++) begin
                if (w_cap[i]) r_slot[i] <= w_in_dsc[i];
            end
            r_dscq_we <= |w_gnt;
            // Data outputs hold between writes.
            if (|w_gnt) begin
                r_dscq_chid <= w_gnt_idx;
                r_dscq_dsc  <= r_slot[w_gnt_idx];
            end
        end
    end

    assign ch_dscq_full       = r_slot_vld;
    assign ch_arb_busy        = r_slot_vld;
    assign ch_set_err_ovfl    = r_err;
    assign dscq_we            = r_dscq_we;
    assign dscq_chid          = r_dscq_chid;
    assign dscq_src_addr      = r_dscq_dsc.src_addr;
    assign dscq_src_len       = r_dscq_dsc.src_len;
    assign dscq_srbuf_rp_pros = r_dscq_dsc.rp_pros;

    // The pointer is only observed through grant order.
    logic w_unused;
    assign w_unused = ^w_ptr;

endmodule
